// File: rtl/xpoint_cfg_seq.sv
// Serial configuration sequencer for the 48x48 crosspoint: buffers route/constant commands
// and shifts each out as a 14-bit CLR/SHIFT/EXEC frame. Optional shadow state: XPCFG_SHADOW_EN.
module xpoint_cfg_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 2
) (
  input  logic       clk_,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [5:0] cmd_out,
  input  logic [5:0] cmd_in,
  input  logic       cmd_disc,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       xp_clk,
  output logic       xp_dat,
  output logic       xp_clear
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned NOUT = 48;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] out;
    logic [5:0] in;
    logic       disc;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_SHIFT, S_EXEC} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            full, push, pop;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      period;
  logic [13:0]     sh;
  logic            tick, period_end, stay_active_c;
  logic            legal_c, skip_c;
  logic [6:0]      hi_c, lo_c;

  // FIFO bookkeeping; a pop always happens in LOAD so a full FIFO can still accept then
  assign full      = (count == CW'(DEPTH));
  assign pop       = (state == S_LOAD);
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk_) begin
    if (push) mem[wr_ptr] <= cmd_t'({cmd_op, cmd_out, cmd_in, cmd_disc});
  end

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Head-of-FIFO decode into frame halves and legality
  always_comb begin
    hi_c    = 7'd0;
    lo_c    = 7'd0;
    legal_c = (head.op != 2'd3) && (head.out < 6'd48) &&
              !((head.op == 2'd0) && !head.disc && (head.in > 6'd47));
    case (head.op)
      2'd0: begin
        hi_c = {1'b0, head.out};
        lo_c = head.disc ? 7'd0 : ({1'b0, head.in} + 7'd1);
      end
      2'd1: begin
        hi_c = 7'd48;
        lo_c = {1'b0, head.out};
      end
      2'd2: begin
        hi_c = 7'd49;
        lo_c = {1'b0, head.out};
      end
      default: begin
        hi_c = 7'd0;
        lo_c = 7'd0;
      end
    endcase
  end

  assign tick       = (div_cnt == DW'(DIV - 1));
  assign period_end = tick && xp_clk;

  // Still mid-work after this edge, independent of FIFO occupancy
  assign stay_active_c = ((state == S_LOAD) && legal_c && !skip_c) ||
                         (state == S_CLR) || (state == S_SHIFT) ||
                         ((state == S_EXEC) && !period_end);

`ifdef XPCFG_SHADOW_EN
  logic [6:0]      route_sh [NOUT];
  logic [NOUT-1:0] one_sh;
  logic [6:0]      hi_q, lo_q;

  always_comb begin
    skip_c = 1'b0;
    case (head.op)
      2'd0:    skip_c = (route_sh[head.out] == lo_c);
      2'd1:    skip_c = one_sh[head.out];
      2'd2:    skip_c = !one_sh[head.out];
      default: skip_c = 1'b0;
    endcase
  end

  // Shadow commits only when the EXEC rising edge has been issued
  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NOUT; i++) route_sh[i] <= '0;
      one_sh <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (state == S_LOAD) begin
      hi_q <= hi_c;
      lo_q <= lo_c;
    end else if ((state == S_EXEC) && period_end) begin
      case (hi_q)
        7'd48:   one_sh[lo_q[5:0]] <= 1'b1;
        7'd49:   one_sh[lo_q[5:0]] <= 1'b0;
        default: route_sh[hi_q[5:0]] <= lo_q;
      endcase
    end
  end
`else
  assign skip_c = 1'b0;
`endif

  // Sequencer: frame timing, serial outputs and status pulses
  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      period   <= '0;
      sh       <= '0;
      xp_clk   <= 1'b0;
      xp_dat   <= 1'b0;
      xp_clear <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      busy <= (count_nxt != '0) || stay_active_c;
      case (state)
        S_IDLE: begin
          if (count != '0) state <= S_LOAD;
        end
        S_LOAD: begin
          if (!legal_c) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else if (skip_c) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            state    <= S_CLR;
            sh       <= {hi_c, lo_c};
            div_cnt  <= '0;
            period   <= '0;
            xp_clk   <= 1'b0;
            xp_clear <= 1'b1;
            xp_dat   <= 1'b0;
          end
        end
        S_CLR, S_SHIFT, S_EXEC: begin
          div_cnt <= tick ? '0 : div_cnt + DW'(1);
          if (tick && !xp_clk) begin
            xp_clk <= 1'b1;
          end else if (period_end) begin
            xp_clk <= 1'b0;
            period <= period + 4'd1;
            if (state == S_CLR) begin
              state    <= S_SHIFT;
              xp_clear <= 1'b0;
              xp_dat   <= sh[13];
              sh       <= {sh[12:0], 1'b0};
            end else if (state == S_SHIFT) begin
              if (period == 4'd14) begin
                state  <= S_EXEC;
                xp_dat <= 1'b0;
              end else begin
                xp_dat <= sh[13];
                sh     <= {sh[12:0], 1'b0};
              end
            end else begin
              done  <= 1'b1;
              state <= (count != '0) ? S_LOAD : S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpoint_cfg_seq.sv
// Randomized self-checking bench for xpoint_cfg_seq; decodes frames from the serial port
// and compares them with a command-level reference model (also covers XPCFG_SHADOW_EN).
module tb_xpoint_cfg_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV   = 2;

  logic       clk_ = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_out;
  logic [5:0] cmd_in;
  logic       cmd_disc;
  logic       busy, done, err;
  logic       xp_clk, xp_dat, xp_clear;

  xpoint_cfg_seq #(.DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk_     (clk_),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_out  (cmd_out),
    .cmd_in   (cmd_in),
    .cmd_disc (cmd_disc),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .xp_clk   (xp_clk),
    .xp_dat   (xp_dat),
    .xp_clear (xp_clear)
  );

  always #5 clk_ = ~clk_;

  int n_chk = 0;
  int n_bad = 0;

  // Monitor-owned state
  int          cyc = 0;
  int          bit_idx = 0;
  int          frames = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          viol = 0;
  int          frame_first_rise = 0;
  int          last_done_cyc = 0;
  int          done_q[$];
  logic [13:0] shw = '0;
  logic [13:0] last_word = '0;
  logic        fmt_ok = 1'b0;
  logic        p_clk = 1'b0, p_dat = 1'b0, p_clr = 1'b0;

  // Stimulus/model-owned state
  logic [13:0] exp_q[$];
  int          exp_done = 0;
  int          exp_err = 0;
  int          n_acc = 0;
  int          acc_cyc = 0;
  int          stall = 0;
  logic        acc_done = 1'b0;
`ifdef XPCFG_SHADOW_EN
  int          sh_route[48];
  bit          sh_one[48];
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    n_acc    = 0;
`ifdef XPCFG_SHADOW_EN
    for (int k = 0; k < 48; k++) begin
      sh_route[k] = 0;
      sh_one[k]   = 1'b0;
    end
`endif
  endtask

  // Command-level reference: legality, frame word, and (optionally) redundant-command skip
  task automatic model_accept(input int op, input int o, input int i, input bit d);
    int hi, lo;
    bit legal, skip;
    legal = (op != 3) && (o < 48) && !(op == 0 && !d && i > 47);
    if (!legal) begin
      exp_err++;
    end else begin
      if (op == 0)      begin hi = o;  lo = d ? 0 : i + 1; end
      else if (op == 1) begin hi = 48; lo = o; end
      else              begin hi = 49; lo = o; end
      skip = 1'b0;
`ifdef XPCFG_SHADOW_EN
      if (op == 0)      begin skip = (sh_route[o] == lo); sh_route[o] = lo; end
      else if (op == 1) begin skip = sh_one[o];  sh_one[o] = 1'b1; end
      else              begin skip = !sh_one[o]; sh_one[o] = 1'b0; end
`endif
      exp_done++;
      if (!skip) exp_q.push_back(14'(hi * 128 + lo));
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [5:0] o, input logic [5:0] i, input logic d);
    int   waitc;
    logic got;
    @(negedge clk_);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_out   = o;
    cmd_in    = i;
    cmd_disc  = d;
    got = 1'b0; waitc = 0; stall = 0; acc_done = 1'b0;
    while (!got && waitc < 3000) begin
      if (cmd_ready) begin
        acc_done = done;
        @(posedge clk_);
        got = 1'b1;
      end else begin
        stall++;
        waitc++;
        @(negedge clk_);
      end
    end
    if (got) begin
      acc_cyc = cyc + 1;
      n_acc++;
      model_accept(int'(op), int'(o), int'(i), d);
      #1;
    end
    cmd_valid = 1'b0;
    chk("push_accept", 32'(got), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk_);
    while (busy && n < 6000) begin
      @(negedge clk_);
      n++;
    end
    repeat (3) @(negedge clk_);
    chk("drain_busy", 32'(busy), 0);
    chk("idle_xp", 32'({xp_clk, xp_dat, xp_clear}), 0);
    chk("done_cnt", done_cnt, exp_done);
    chk("err_cnt", err_cnt, exp_err);
    chk("frames_left", exp_q.size(), 0);
    chk("no_partial", bit_idx, 0);
  endtask

  task automatic full_reset();
    @(negedge clk_);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_);
    #2 rst = 1'b0;
  endtask

  // Serial-port decoder and status-pulse monitor
  always @(negedge clk_) begin
    cyc = cyc + 1;
    if (rst) begin
      bit_idx  = 0;
      done_cnt = 0;
      err_cnt  = 0;
      p_clk = 1'b0; p_dat = 1'b0; p_clr = 1'b0;
    end else begin
      if ((xp_dat !== p_dat || xp_clear !== p_clr) && !(!xp_clk && (p_clk || bit_idx == 0)))
        viol++;
      if (xp_clk && !p_clk) begin
        if (bit_idx == 0) begin
          fmt_ok = xp_clear && !xp_dat;
          frame_first_rise = cyc;
          shw = '0;
        end else if (bit_idx < 15) begin
          fmt_ok = fmt_ok && !xp_clear;
          shw = {shw[12:0], xp_dat};
        end else begin
          fmt_ok = fmt_ok && !xp_clear && !xp_dat;
          frames++;
          last_word = shw;
          chk("frame_fmt", 32'(fmt_ok), 1);
          chk("frame_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("frame_word", 32'(shw), 32'(exp_q.pop_front()));
        end
        bit_idx = (bit_idx == 15) ? 0 : bit_idx + 1;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        done_q.push_back(cyc);
        chk("busy_at_done", 32'(busy), 32'((n_acc - done_cnt - err_cnt) != 0));
      end
      if (err) begin
        err_cnt++;
        chk("busy_at_err", 32'(busy), 32'((n_acc - done_cnt - err_cnt) != 0));
      end
      p_clk = xp_clk;
      p_dat = xp_dat;
      p_clr = xp_clear;
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish, want finish by 600us");
    $fatal(1, "bench timeout");
  end

  initial begin
    int a1, f0, d0, ssum, n;
    logic [1:0] op;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_out = '0; cmd_in = '0; cmd_disc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_xp", 32'({xp_clk, xp_dat, xp_clear}), 0);
    #2 rst = 1'b0;

    // Single route, frame word and latency
    push(2'd0, 6'd5, 6'd3, 1'b0);
    a1 = acc_cyc;
    drain();
    chk("t1_word", 32'(last_word), 32'h0284);
    chk("t1_first_rise", frame_first_rise - a1, 2 + DIV);
    chk("t1_done_lat", last_done_cyc - frame_first_rise, 31 * DIV);

    // Constant-one set then clear
    f0 = frames;
    push(2'd1, 6'd47, 6'd0, 1'b0);
    push(2'd2, 6'd47, 6'd0, 1'b0);
    drain();
    chk("t2_frames", frames - f0, 2);

    // Backlog: FIFO fills while a frame runs, throughput with back-to-back frames
    d0 = done_q.size();
    push(2'd0, 6'd9, 6'd1, 1'b0);
    repeat (8) @(negedge clk_);
    ssum = 0;
    for (int k = 0; k < 4; k++) begin
      push(2'd0, 6'(10 + k), 6'(k + 2), 1'b0);
      ssum += stall;
    end
    chk("burst_nostall", ssum, 0);
    push(2'd0, 6'd14, 6'd7, 1'b0);
    chk("burst_stall5", 32'(stall > 0), 1);
    chk("burst_ready_at_pop", 32'(acc_done), 1);
    drain();
    if (done_q.size() >= d0 + 6) begin
      for (int k = 1; k < 6; k++)
        chk("throughput", done_q[d0 + k] - done_q[d0 + k - 1], 32 * DIV + 1);
    end else begin
      chk("burst_dones", done_q.size() - d0, 6);
    end

    // Illegal commands interleaved with legal ones
    push(2'd0, 6'd20, 6'd4, 1'b0);
    push(2'd0, 6'd48, 6'd1, 1'b0);
    push(2'd1, 6'd21, 6'd0, 1'b0);
    push(2'd3, 6'd3, 6'd3, 1'b0);
    push(2'd0, 6'd22, 6'd50, 1'b0);
    push(2'd2, 6'd21, 6'd0, 1'b0);
    push(2'd0, 6'd23, 6'd60, 1'b1);
    drain();

    // Random traffic with idle gaps of varying length
    for (int k = 0; k < 30; k++) begin
      n = int'($urandom_range(0, 9));
      op = (n < 5) ? 2'd0 : (n < 7) ? 2'd1 : (n < 9) ? 2'd2 : 2'd3;
      repeat ($urandom_range(0, 70)) @(negedge clk_);
      push(op, 6'($urandom_range(0, 49)), 6'($urandom_range(0, 49)), 1'($urandom_range(0, 3) == 0));
    end
    drain();

    // Reset during word bit 7 with commands still queued
    push(2'd0, 6'd30, 6'd12, 1'b0);
    push(2'd0, 6'd31, 6'd13, 1'b0);
    push(2'd1, 6'd5, 6'd0, 1'b0);
    n = 0;
    while (bit_idx < 8 && n < 2000) begin
      @(posedge clk_);
      n++;
    end
    chk("t6_reached_bit7", 32'(bit_idx >= 8), 1);
    @(negedge clk_);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_xp_clk", 32'(xp_clk), 0);
    chk("t6_xp_dat", 32'(xp_dat), 0);
    chk("t6_xp_clear", 32'(xp_clear), 0);
    chk("t6_ready", 32'(cmd_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    repeat (2) @(negedge clk_);
    #2 rst = 1'b0;
    f0 = frames;
    repeat (150) @(negedge clk_);
    chk("t6_flushed", frames - f0, 0);
    chk("t6_idle_busy", 32'(busy), 0);
    push(2'd0, 6'd30, 6'd12, 1'b0);
    drain();
    chk("t6_frame", frames - f0, 1);

    // Repeated route; redundant with the shadow enabled
    f0 = frames;
    push(2'd0, 6'd2, 6'd1, 1'b0);
    push(2'd0, 6'd2, 6'd1, 1'b0);
    drain();
`ifdef XPCFG_SHADOW_EN
    chk("t7_repeat_frames", frames - f0, 1);
`else
    chk("t7_repeat_frames", frames - f0, 2);
`endif
    full_reset();
    f0 = frames;
    push(2'd0, 6'd0, 6'd9, 1'b1);
    drain();
`ifdef XPCFG_SHADOW_EN
    chk("t7_disc_frames", frames - f0, 0);
`else
    chk("t7_disc_frames", frames - f0, 1);
`endif

    chk("setup_changes", viol, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
